vga_scan: RTL and testbench
===========================

Name: vga_scan

Overview:
- Parametrised VGA scan-out engine. Generates H/V timing and VRAM read addresses, and drives blanked colour plus sync to the pins.
- Successor to the fixed 640x480 vga block. Adds configurable timing, sync polarity, colour width, VRAM read latency, a pixel-clock divider and integer framebuffer upscaling.
- Sits between the VRAM read port and the board VGA connector, in the VGAclk domain.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, HSync level during the sync pulse
- VS_POL, 0, VSync level during the sync pulse
- CW, 12, colour width
- AW, 19, VRAM address width
- RD_LAT, 1, VRAM read latency in clocks (1..4)
- SCALE_LOG2, 0, framebuffer downscale shift (0..2); framebuffer is (H_ACTIVE>>S) x (V_ACTIVE>>S)
- DIV, 1, VGAclk cycles per pixel (1..4)

Ports:
- VGAclk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- RAddr  out  AW  VRAM read address
- RE  out  1  VRAM read enable
- RData  in  CW  VRAM read data, valid RD_LAT clocks after RAddr/RE
- vgaRBG  out  CW  pixel colour, 0 during blanking
- HSync  out  1  horizontal sync
- VSync  out  1  vertical sync
- Active  out  1  display-enable, aligned with vgaRBG
- FrameStart  out  1  one-clock pulse, aligned with the first clock of output pixel (0,0)

Behaviour:
- Clock and reset: single clock VGAclk. Reset rst is synchronous and active-high.
- Derived totals: H_TOTAL = sum of the four H params (default 800); V_TOTAL = sum of the four V params (default 525).
- Pixel divider: counter runs 0..DIV-1; tick is asserted on DIV-1. With DIV=1, tick is asserted every clock.
- Counters: hcnt advances on tick and wraps at H_TOTAL-1 to 0. On that wrap, vcnt increments and wraps at V_TOTAL-1 to 0.
- Horizontal regions: active [0,H_ACTIVE), front porch, sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), back porch. Vertical regions are identical using the V params.
- Address generation (no multiplier):
  - line_base register resets to 0.
  - On hcnt wrap with vcnt<V_ACTIVE-1 and ((vcnt+1) mod 2^S)==0: line_base += H_ACTIVE>>S.
  - On frame wrap: line_base = 0.
- Stage 0 (registered):
  - RE = active(hcnt,vcnt)
  - RAddr = line_base + (hcnt>>S), updated only while active; holds its last value during blanking.
  - RAddr is stable for all DIV clocks of a pixel; RE stays high for every clock of an active pixel.
- Delay pipe: active, hsync-region, vsync-region and frame-start flags are delayed RD_LAT clocks to align with RData.
- Output register (one further clock):
  - vgaRBG = act_d ? RData : 0
  - HSync = hs_d ? HS_POL : ~HS_POL; VSync likewise with VS_POL.
  - Active = act_d
  - FrameStart = pulse for the first clock of pixel (0,0).
- Latency: counter state to pins is RD_LAT+2 clocks. All pin outputs are mutually aligned.
- Reset values:
  - Counters, divider and line_base are 0.
  - RE = 0, RAddr = 0.
  - Delay pipe is filled with inactive values.
  - vgaRBG = 0, Active = 0, FrameStart = 0, HSync = ~HS_POL, VSync = ~VS_POL.
- Reset mid-frame: the next clock shows all outputs inactive. The scan restarts at (0,0); no partial-line artefacts leave the pipe as active.
- Blanking: vgaRBG = 0 regardless of RData.
- Boundaries: RAddr never exceeds (H_ACTIVE>>S)*(V_ACTIVE>>S)-1.
- Elaboration checks: RD_LAT, SCALE_LOG2 and DIV outside their ranges fail elaboration. A framebuffer size exceeding 2^AW also fails elaboration.

Decomposition:
- Shared package vga_pkg:
  - default 640x480@60 timing constants
  - polarity constants ACTIVE_LOW/ACTIVE_HIGH
  - functions h_total/v_total
  - range-check helpers
- Sub-module vga_timing: divider, hcnt/vcnt, region decode; outputs tick, active, hs, vs, frame_start, hcnt, vcnt.
- vga_scan: address generation, delay pipe, output register.

Test Plan:
1. Reset: hold rst 3 clocks, release.
   - While rst is high: HSync=1, VSync=1, vgaRBG=0, Active=0, RE=0.
   - RE=1 with RAddr=0 one clock after release; Active rises RD_LAT+2 clocks after release.
2. Defaults, line timing:
   - HSync low exactly 96 clocks every 800.
   - Active high 640 clocks per visible line; 0 for lines 480..524.
3. Data path, RD_LAT=2, memory model RData=RAddr[11:0]:
   - vgaRBG at (x=5,y=0) = 12'h005.
   - vgaRBG at (x=0,y=1) = 12'h280.
   - vgaRBG = 0 throughout blanking.
4. Scaling, SCALE_LOG2=1:
   - RAddr at (3,3) = 321.
   - RAddr at (639,479) = 76799.
   - Lines 0 and 1 present identical address sequences.
5. Frame timing:
   - VSync low for lines 490-491 (1600 clocks).
   - FrameStart pulses every 420000 clocks and coincides with the first Active rise of the frame.
6. Reset mid-line at hcnt=300: next clock outputs are inactive, and the scan restarts at (0,0).
7. Divider, DIV=2: HSync low 192 clocks, period 1600; RAddr is held 2 clocks per pixel.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared constants, flag bundle and elaboration helpers for the VGA scan-out engine.
// Defaults describe 640x480@60 with a 25.175 MHz pixel clock.
package vga_pkg;

    localparam int unsigned DEF_H_ACTIVE = 32'd640;
    localparam int unsigned DEF_H_FP     = 32'd16;
    localparam int unsigned DEF_H_SYNC   = 32'd96;
    localparam int unsigned DEF_H_BP     = 32'd48;
    localparam int unsigned DEF_V_ACTIVE = 32'd480;
    localparam int unsigned DEF_V_FP     = 32'd10;
    localparam int unsigned DEF_V_SYNC   = 32'd2;
    localparam int unsigned DEF_V_BP     = 32'd33;

    localparam logic ACTIVE_LOW  = 1'b0;
    localparam logic ACTIVE_HIGH = 1'b1;

    typedef struct packed {
        logic act;
        logic hs;
        logic vs;
        logic fs;
    } scan_flags_t;

    localparam scan_flags_t FLAGS_IDLE = '{act: 1'b0, hs: 1'b0, vs: 1'b0, fs: 1'b0};

    function automatic int unsigned h_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int unsigned v_total(input int unsigned act, input int unsigned fp,
                                            input int unsigned sync, input int unsigned bp);
        return act + fp + sync + bp;
    endfunction

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 32'd2) ? $clog2(n) : 32'd1;
    endfunction

    function automatic bit in_range(input int unsigned v, input int unsigned lo,
                                    input int unsigned hi);
        return (v >= lo) && (v <= hi);
    endfunction

    // The scaled framebuffer must be addressable with AW bits.
    function automatic bit fb_fits(input int unsigned ha, input int unsigned va,
                                   input int unsigned s, input int unsigned aw);
        longint unsigned fb;
        fb = longint'(ha >> s) * longint'(va >> s);
        return fb <= (64'd1 << aw);
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel divider, horizontal/vertical counters and region decode.
// Region flags are decoded from the current counter state.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
    parameter int unsigned H_FP     = DEF_H_FP,
    parameter int unsigned H_SYNC   = DEF_H_SYNC,
    parameter int unsigned H_BP     = DEF_H_BP,
    parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
    parameter int unsigned V_FP     = DEF_V_FP,
    parameter int unsigned V_SYNC   = DEF_V_SYNC,
    parameter int unsigned V_BP     = DEF_V_BP,
    parameter int unsigned DIV      = 32'd1,
    localparam int unsigned HW = cnt_width(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
    localparam int unsigned VW = cnt_width(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
    input  logic          i_clk,
    input  logic          i_rst,
    output logic          o_tick,
    output logic          o_active,
    output logic          o_hs,
    output logic          o_vs,
    output logic          o_frame_start,
    output logic [HW-1:0] o_hcnt,
    output logic [VW-1:0] o_vcnt
);

    localparam int unsigned H_TOTAL = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int unsigned V_TOTAL = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 32'd1);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 32'd1);
    localparam logic [HW-1:0] H_ONE  = HW'(32'd1);
    localparam logic [VW-1:0] V_ONE  = VW'(32'd1);
    localparam logic [1:0]    DIV_LAST = 2'(DIV - 32'd1);

    logic [1:0]    r_div;
    logic [HW-1:0] r_hcnt;
    logic [VW-1:0] r_vcnt;
    logic [31:0]   w_h;
    logic [31:0]   w_v;

    assign w_h    = 32'(r_hcnt);
    assign w_v    = 32'(r_vcnt);
    assign o_tick = (r_div == DIV_LAST);

    // Divider and raster counters; vcnt only moves on the last pixel of a line.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_div  <= 2'd0;
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else begin
            r_div <= o_tick ? 2'd0 : (r_div + 2'd1);
            if (o_tick) begin
                if (r_hcnt == H_LAST) begin
                    r_hcnt <= '0;
                    r_vcnt <= (r_vcnt == V_LAST) ? '0 : (r_vcnt + V_ONE);
                end else begin
                    r_hcnt <= r_hcnt + H_ONE;
                end
            end
        end
    end

    assign o_active      = (w_h < H_ACTIVE) && (w_v < V_ACTIVE);
    assign o_hs          = (w_h >= H_ACTIVE + H_FP) && (w_h < H_ACTIVE + H_FP + H_SYNC);
    assign o_vs          = (w_v >= V_ACTIVE + V_FP) && (w_v < V_ACTIVE + V_FP + V_SYNC);
    assign o_frame_start = (r_hcnt == '0) && (r_vcnt == '0) && (r_div == 2'd0);
    assign o_hcnt        = r_hcnt;
    assign o_vcnt        = r_vcnt;

endmodule

// File: rtl/vga_scan.sv
// VGA scan-out top: VRAM address generation, read-latency delay pipe and pin register.
// Pins trail the raster counters by RD_LAT+2 clocks and are mutually aligned.
module vga_scan
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = DEF_H_ACTIVE,
    parameter int unsigned H_FP       = DEF_H_FP,
    parameter int unsigned H_SYNC     = DEF_H_SYNC,
    parameter int unsigned H_BP       = DEF_H_BP,
    parameter int unsigned V_ACTIVE   = DEF_V_ACTIVE,
    parameter int unsigned V_FP       = DEF_V_FP,
    parameter int unsigned V_SYNC     = DEF_V_SYNC,
    parameter int unsigned V_BP       = DEF_V_BP,
    parameter logic        HS_POL     = ACTIVE_LOW,
    parameter logic        VS_POL     = ACTIVE_LOW,
    parameter int unsigned CW         = 32'd12,
    parameter int unsigned AW         = 32'd19,
    parameter int unsigned RD_LAT     = 32'd1,
    parameter int unsigned SCALE_LOG2 = 32'd0,
    parameter int unsigned DIV        = 32'd1
) (
    input  logic          VGAclk,
    input  logic          rst,
    output logic [AW-1:0] RAddr,
    output logic          RE,
    input  logic [CW-1:0] RData,
    output logic [CW-1:0] vgaRBG,
    output logic          HSync,
    output logic          VSync,
    output logic          Active,
    output logic          FrameStart
);

    localparam int unsigned HW = cnt_width(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
    localparam int unsigned VW = cnt_width(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
    localparam logic [HW-1:0] H_LAST = HW'(h_total(H_ACTIVE, H_FP, H_SYNC, H_BP) - 32'd1);
    localparam logic [VW-1:0] V_LAST = VW'(v_total(V_ACTIVE, V_FP, V_SYNC, V_BP) - 32'd1);
    localparam logic [AW-1:0] LINE_STEP = AW'(H_ACTIVE >> SCALE_LOG2);
    localparam int unsigned   ROW_MASK  = (32'd1 << SCALE_LOG2) - 32'd1;

    if (!in_range(RD_LAT, 32'd1, 32'd4)) begin : g_bad_rd_lat
        $error("vga_scan: RD_LAT must be 1..4");
    end
    if (!in_range(SCALE_LOG2, 32'd0, 32'd2)) begin : g_bad_scale
        $error("vga_scan: SCALE_LOG2 must be 0..2");
    end
    if (!in_range(DIV, 32'd1, 32'd4)) begin : g_bad_div
        $error("vga_scan: DIV must be 1..4");
    end
    if (!fb_fits(H_ACTIVE, V_ACTIVE, SCALE_LOG2, AW)) begin : g_bad_aw
        $error("vga_scan: framebuffer does not fit in 2^AW words");
    end

    logic          w_tick;
    logic          w_active;
    logic          w_hs;
    logic          w_vs;
    logic          w_frame_start;
    logic [HW-1:0] w_hcnt;
    logic [VW-1:0] w_vcnt;
    logic          w_line_end;
    logic          w_frame_end;
    logic          w_row_step;
    logic [AW-1:0] w_col;
    scan_flags_t   w_tail;

    logic [AW-1:0] r_line_base;
    logic [AW-1:0] r_raddr;
    scan_flags_t   r_s0;
    scan_flags_t   r_pipe [0:RD_LAT-1];
    logic [CW-1:0] r_rgb;
    logic          r_hsync;
    logic          r_vsync;
    logic          r_active;
    logic          r_frame_start;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .DIV      (DIV)
    ) u_timing (
        .i_clk         (VGAclk),
        .i_rst         (rst),
        .o_tick        (w_tick),
        .o_active      (w_active),
        .o_hs          (w_hs),
        .o_vs          (w_vs),
        .o_frame_start (w_frame_start),
        .o_hcnt        (w_hcnt),
        .o_vcnt        (w_vcnt)
    );

    // A framebuffer row is reused for 2^S display lines, so the base only steps
    // after the last display line of each group (and never past the last row).
    assign w_line_end  = w_tick && (w_hcnt == H_LAST);
    assign w_frame_end = w_line_end && (w_vcnt == V_LAST);
    assign w_row_step  = (((32'(w_vcnt) + 32'd1) & ROW_MASK) == 32'd0) &&
                         (32'(w_vcnt) < V_ACTIVE - 32'd1);
    assign w_col       = AW'(32'(w_hcnt) >> SCALE_LOG2);

    // Row base address accumulator, replacing a y*width multiply.
    always_ff @(posedge VGAclk) begin
        if (rst) begin
            r_line_base <= '0;
        end else if (w_frame_end) begin
            r_line_base <= '0;
        end else if (w_line_end && w_row_step) begin
            r_line_base <= r_line_base + LINE_STEP;
        end
    end

    // Stage 0: read request and the raster flags that must travel with it.
    always_ff @(posedge VGAclk) begin
        if (rst) begin
            r_raddr <= '0;
            r_s0    <= FLAGS_IDLE;
        end else begin
            if (w_active) begin
                r_raddr <= r_line_base + w_col;
            end
            r_s0 <= '{act: w_active, hs: w_hs, vs: w_vs, fs: w_frame_start};
        end
    end

    // Delay the flags by the VRAM read latency so they line up with RData.
    always_ff @(posedge VGAclk) begin
        if (rst) begin
            for (int i = 0; i < int'(RD_LAT); i++) begin
                r_pipe[i] <= FLAGS_IDLE;
            end
        end else begin
            r_pipe[0] <= r_s0;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_tail = r_pipe[RD_LAT-1];

    // Pin register: blanked colour and polarity-corrected syncs.
    always_ff @(posedge VGAclk) begin
        if (rst) begin
            r_rgb         <= '0;
            r_hsync       <= ~HS_POL;
            r_vsync       <= ~VS_POL;
            r_active      <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_rgb         <= w_tail.act ? RData : '0;
            r_hsync       <= w_tail.hs ? HS_POL : ~HS_POL;
            r_vsync       <= w_tail.vs ? VS_POL : ~VS_POL;
            r_active      <= w_tail.act;
            r_frame_start <= w_tail.fs;
        end
    end

    assign RAddr      = r_raddr;
    assign RE         = r_s0.act;
    assign vgaRBG     = r_rgb;
    assign HSync      = r_hsync;
    assign VSync      = r_vsync;
    assign Active     = r_active;
    assign FrameStart = r_frame_start;

endmodule

// File: tb/tb_vga_scan.sv
// Self-checking bench for vga_scan: four configurations run side by side, each compared
// cycle by cycle against a raster-position model; VRAM returns random junk when RE is low.
module tb_vga_scan;

    typedef struct packed {
        logic        re;
        logic [31:0] raddr;
        logic [31:0] rgb;
        logic        hs;
        logic        vs;
        logic        act;
        logic        fs;
    } pins_t;

    typedef struct {
        int ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
        int lat, s, div, cw;
        bit hpol, vpol;
    } cfg_t;

    logic       clk = 1'b0;
    logic [3:0] rst_v = 4'b1111;
    int         n_cnt [4];
    pins_t      obs [4];
    cfg_t       cfg [4];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    // A: default timing, RD_LAT=2.  B: SCALE_LOG2=1.  C: DIV=2, RD_LAT=3.  D: tiny raster.
    logic [18:0] raddr_a, raddr_b, raddr_c;
    logic [4:0]  raddr_d;
    logic [11:0] rdata_a, rdata_b, rdata_c, rgb_a, rgb_b, rgb_c;
    logic [7:0]  rdata_d, rgb_d;
    logic re_a, re_b, re_c, re_d, hs_a, hs_b, hs_c, hs_d, vs_a, vs_b, vs_c, vs_d;
    logic act_a, act_b, act_c, act_d, fs_a, fs_b, fs_c, fs_d;

    vga_scan #(.RD_LAT(2)) dut_a (
        .VGAclk(clk), .rst(rst_v[0]), .RAddr(raddr_a), .RE(re_a), .RData(rdata_a),
        .vgaRBG(rgb_a), .HSync(hs_a), .VSync(vs_a), .Active(act_a), .FrameStart(fs_a));
    vga_scan #(.SCALE_LOG2(1)) dut_b (
        .VGAclk(clk), .rst(rst_v[1]), .RAddr(raddr_b), .RE(re_b), .RData(rdata_b),
        .vgaRBG(rgb_b), .HSync(hs_b), .VSync(vs_b), .Active(act_b), .FrameStart(fs_b));
    vga_scan #(.DIV(2), .RD_LAT(3)) dut_c (
        .VGAclk(clk), .rst(rst_v[2]), .RAddr(raddr_c), .RE(re_c), .RData(rdata_c),
        .vgaRBG(rgb_c), .HSync(hs_c), .VSync(vs_c), .Active(act_c), .FrameStart(fs_c));
    vga_scan #(.H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3), .V_ACTIVE(8), .V_FP(2),
               .V_SYNC(2), .V_BP(3), .HS_POL(1'b1), .VS_POL(1'b0), .CW(8), .AW(5),
               .RD_LAT(1), .SCALE_LOG2(1), .DIV(1)) dut_d (
        .VGAclk(clk), .rst(rst_v[3]), .RAddr(raddr_d), .RE(re_d), .RData(rdata_d),
        .vgaRBG(rgb_d), .HSync(hs_d), .VSync(vs_d), .Active(act_d), .FrameStart(fs_d));

    logic [11:0] mp_a [2];
    logic [11:0] mp_b [1];
    logic [11:0] mp_c [3];
    logic [7:0]  mp_d [1];

    // VRAM models: data = address while reading, random junk otherwise.
    always @(posedge clk) begin
        mp_a[0] <= re_a ? raddr_a[11:0] : 12'($urandom);
        mp_a[1] <= mp_a[0];
        mp_b[0] <= re_b ? raddr_b[11:0] : 12'($urandom);
        mp_c[0] <= re_c ? raddr_c[11:0] : 12'($urandom);
        mp_c[1] <= mp_c[0];
        mp_c[2] <= mp_c[1];
        mp_d[0] <= re_d ? 8'(raddr_d) : 8'($urandom);
    end
    assign rdata_a = mp_a[1];
    assign rdata_b = mp_b[0];
    assign rdata_c = mp_c[2];
    assign rdata_d = mp_d[0];

    assign obs[0] = {re_a, 32'(raddr_a), 32'(rgb_a), hs_a, vs_a, act_a, fs_a};
    assign obs[1] = {re_b, 32'(raddr_b), 32'(rgb_b), hs_b, vs_b, act_b, fs_b};
    assign obs[2] = {re_c, 32'(raddr_c), 32'(rgb_c), hs_c, vs_c, act_c, fs_c};
    assign obs[3] = {re_d, 32'(raddr_d), 32'(rgb_d), hs_d, vs_d, act_d, fs_d};

    // Clock edges seen with reset low since the last reset edge, per DUT.
    always @(posedge clk) begin
        for (int d = 0; d < 4; d++) n_cnt[d] <= rst_v[d] ? 0 : n_cnt[d] + 1;
    end

    // Expected pins after n edges out of reset, from the raster position alone.
    function automatic pins_t model(input cfg_t c, input int n);
        pins_t r;
        int ht, vt, q, p, pix, x, y, lx, ly;
        ht = c.ha + c.hfp + c.hsw + c.hbp;
        vt = c.va + c.vfp + c.vsw + c.vbp;
        r = '0;
        r.hs = ~c.hpol;
        r.vs = ~c.vpol;
        if (n >= 1) begin
            q = n - 1;
            pix = q / c.div;
            x = pix % ht;
            y = (pix / ht) % vt;
            r.re = (x < c.ha) && (y < c.va);
            lx = (x < c.ha) ? x : c.ha - 1;
            ly = y;
            if (y >= c.va) begin
                lx = c.ha - 1;
                ly = c.va - 1;
            end
            r.raddr = 32'((ly >> c.s) * (c.ha >> c.s) + (lx >> c.s));
        end
        p = n - (c.lat + 2);
        if (p >= 0) begin
            pix = p / c.div;
            x = pix % ht;
            y = (pix / ht) % vt;
            r.act = (x < c.ha) && (y < c.va);
            r.hs = (x >= c.ha + c.hfp && x < c.ha + c.hfp + c.hsw) ? c.hpol : ~c.hpol;
            r.vs = (y >= c.va + c.vfp && y < c.va + c.vfp + c.vsw) ? c.vpol : ~c.vpol;
            r.rgb = r.act ? 32'(((y >> c.s) * (c.ha >> c.s) + (x >> c.s)) & ((1 << c.cw) - 1)) : 32'd0;
            r.fs = (x == 0) && (y == 0) && (p % c.div == 0);
        end
        return r;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int d, input int len);
        rst_v[d] = 1'b1;
        repeat (len) cyc();
        rst_v[d] = 1'b0;
    endtask

    task automatic test_reset();
        rst_v[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            checks++;
            if ({hs_a, vs_a, rgb_a, act_a, re_a} !== {1'b1, 1'b1, 12'h000, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold got hs=%b vs=%b rgb=%h act=%b re=%b want 1 1 000 0 0",
                         hs_a, vs_a, rgb_a, act_a, re_a);
            end
        end
        rst_v[0] = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            cyc();
            checks++;
            if (re_a !== 1'b1 || raddr_a !== 19'(k - 1) || act_a !== (k >= 4) || fs_a !== (k == 4)) begin
                errors++;
                $display("FAIL reset_release clk=%0d got re=%b addr=%0d act=%b fs=%b want 1 %0d %b %b",
                         k, re_a, raddr_a, act_a, fs_a, k - 1, k >= 4, k == 4);
            end
        end
    endtask

    task automatic test_line_and_data();
        int hs_low [3];
        int act_hi [3];
        int blank_bad;
        pins_t e;
        int p;
        hs_low = '{0, 0, 0};
        act_hi = '{0, 0, 0};
        blank_bad = 0;
        do_reset(0, $urandom_range(1, 4));
        for (int i = 0; i < 2400 + 4; i++) begin
            cyc();
            e = model(cfg[0], n_cnt[0]);
            checks++;
            if (obs[0] !== e) begin
                errors++;
                $display("FAIL line_model n=%0d got=%h want=%h", n_cnt[0], obs[0], e);
            end
            p = n_cnt[0] - 4;
            if (p >= 0 && p < 2400) begin
                hs_low[p / 800] += (hs_a == 1'b0) ? 1 : 0;
                act_hi[p / 800] += (act_a == 1'b1) ? 1 : 0;
                if (!act_a && rgb_a != 12'h000) blank_bad++;
            end
            if (p == 5 || p == 800) begin
                checks++;
                if (rgb_a !== ((p == 5) ? 12'h005 : 12'h280)) begin
                    errors++;
                    $display("FAIL pixel_data p=%0d got %h want %h", p, rgb_a, (p == 5) ? 12'h005 : 12'h280);
                end
            end
        end
        for (int l = 0; l < 3; l++) begin
            checks++;
            if (hs_low[l] != 96 || act_hi[l] != 640) begin
                errors++;
                $display("FAIL line_counts line=%0d got hs_low=%0d act=%0d want 96 640", l, hs_low[l], act_hi[l]);
            end
        end
        checks++;
        if (blank_bad != 0) begin
            errors++;
            $display("FAIL blank_colour got %0d nonzero blank pixels want 0", blank_bad);
        end
    endtask

    task automatic test_mid_reset();
        int target;
        pins_t e;
        target = $urandom_range(0, 2) * 800 + 300;
        do_reset(0, 2);
        for (int i = 0; i < 3000 && n_cnt[0] != target; i++) cyc();
        checks++;
        if (n_cnt[0] != target) begin
            errors++;
            $display("FAIL mid_reset_reach got n=%0d want %0d", n_cnt[0], target);
        end
        rst_v[0] = 1'b1;
        cyc();
        checks++;
        if ({re_a, rgb_a, act_a, fs_a, hs_a, vs_a} !== {1'b0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL mid_reset_idle got re=%b rgb=%h act=%b fs=%b hs=%b vs=%b want 0 000 0 0 1 1",
                     re_a, rgb_a, act_a, fs_a, hs_a, vs_a);
        end
        repeat ($urandom_range(0, 2)) cyc();
        rst_v[0] = 1'b0;
        for (int i = 0; i < 900; i++) begin
            cyc();
            e = model(cfg[0], n_cnt[0]);
            checks++;
            if (obs[0] !== e) begin
                errors++;
                $display("FAIL restart_model n=%0d got=%h want=%h", n_cnt[0], obs[0], e);
            end
        end
    endtask

    task automatic test_scaling();
        int al [2][640];
        int q, bad;
        pins_t e;
        do_reset(1, $urandom_range(1, 3));
        for (int i = 0; i < 2405; i++) begin
            cyc();
            e = model(cfg[1], n_cnt[1]);
            checks++;
            if (obs[1] !== e) begin
                errors++;
                $display("FAIL scale_model n=%0d got=%h want=%h", n_cnt[1], obs[1], e);
            end
            q = n_cnt[1] - 1;
            if (q < 1600 && (q % 800) < 640) al[q / 800][q % 800] = int'(raddr_b);
            if (q == 3 * 800 + 3) begin
                checks++;
                if (raddr_b !== 19'd321) begin
                    errors++;
                    $display("FAIL scale_addr_3_3 got %0d want 321", raddr_b);
                end
            end
        end
        bad = 0;
        for (int x = 0; x < 640; x++) if (al[0][x] != al[1][x] || al[0][x] != x / 2) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL scale_rows_repeat got %0d differing columns want 0", bad);
        end
    endtask

    task automatic test_divider();
        int hs_low [3];
        int prev, q, p;
        pins_t e;
        hs_low = '{0, 0, 0};
        prev = 0;
        do_reset(2, $urandom_range(1, 3));
        for (int i = 0; i < 4800 + 5; i++) begin
            cyc();
            e = model(cfg[2], n_cnt[2]);
            checks++;
            if (obs[2] !== e) begin
                errors++;
                $display("FAIL div_model n=%0d got=%h want=%h", n_cnt[2], obs[2], e);
            end
            q = n_cnt[2] - 1;
            if (q % 2 == 1 && re_c) begin
                checks++;
                if (int'(raddr_c) != prev) begin
                    errors++;
                    $display("FAIL div_addr_hold q=%0d got %0d want %0d", q, raddr_c, prev);
                end
            end
            prev = int'(raddr_c);
            p = n_cnt[2] - 5;
            if (p >= 0 && p < 4800) hs_low[p / 1600] += (hs_c == 1'b0) ? 1 : 0;
        end
        for (int l = 0; l < 3; l++) begin
            checks++;
            if (hs_low[l] != 192) begin
                errors++;
                $display("FAIL div_hsync line=%0d got %0d low clocks want 192", l, hs_low[l]);
            end
        end
    endtask

    task automatic test_frame();
        int vs_low [3];
        int last_fs, max_addr, p;
        logic prev_act;
        pins_t e;
        vs_low = '{0, 0, 0};
        last_fs = -1;
        max_addr = 0;
        prev_act = 1'b0;
        do_reset(3, $urandom_range(1, 3));
        for (int i = 0; i < 1080 + 3; i++) begin
            cyc();
            e = model(cfg[3], n_cnt[3]);
            checks++;
            if (obs[3] !== e) begin
                errors++;
                $display("FAIL frame_model n=%0d got=%h want=%h", n_cnt[3], obs[3], e);
            end
            p = n_cnt[3] - 3;
            if (p >= 0 && p < 1080) vs_low[p / 360] += (vs_d == 1'b0) ? 1 : 0;
            if (int'(raddr_d) > max_addr) max_addr = int'(raddr_d);
            if (fs_d) begin
                checks++;
                if (!act_d || prev_act || (last_fs >= 0 && p - last_fs != 360)) begin
                    errors++;
                    $display("FAIL frame_start p=%0d got act=%b prev_act=%b gap=%0d want 1 0 360",
                             p, act_d, prev_act, p - last_fs);
                end
                last_fs = p;
            end
            prev_act = act_d;
        end
        for (int f = 0; f < 3; f++) begin
            checks++;
            if (vs_low[f] != 48) begin
                errors++;
                $display("FAIL frame_vsync frame=%0d got %0d low clocks want 48", f, vs_low[f]);
            end
        end
        checks++;
        if (max_addr != 31) begin
            errors++;
            $display("FAIL frame_addr_max got %0d want 31", max_addr);
        end
    endtask

    task automatic test_back_to_back();
        pins_t e;
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < int'($urandom_range(20, 700)); i++) begin
                cyc();
                e = model(cfg[3], n_cnt[3]);
                checks++;
                if (obs[3] !== e) begin
                    errors++;
                    $display("FAIL b2b_model round=%0d n=%0d got=%h want=%h", r, n_cnt[3], obs[3], e);
                end
            end
            rst_v[3] = 1'b1;
            for (int j = 0; j < int'($urandom_range(1, 3)); j++) begin
                cyc();
                e = model(cfg[3], n_cnt[3]);
                checks++;
                if (obs[3] !== e) begin
                    errors++;
                    $display("FAIL b2b_reset round=%0d got=%h want=%h", r, obs[3], e);
                end
            end
            rst_v[3] = 1'b0;
        end
    endtask

    initial begin
        cfg[0] = '{ha: 640, hfp: 16, hsw: 96, hbp: 48, va: 480, vfp: 10, vsw: 2, vbp: 33,
                   lat: 2, s: 0, div: 1, cw: 12, hpol: 1'b0, vpol: 1'b0};
        cfg[1] = cfg[0];
        cfg[1].lat = 1;
        cfg[1].s = 1;
        cfg[2] = cfg[0];
        cfg[2].lat = 3;
        cfg[2].div = 2;
        cfg[3] = '{ha: 16, hfp: 2, hsw: 3, hbp: 3, va: 8, vfp: 2, vsw: 2, vbp: 3,
                   lat: 1, s: 1, div: 1, cw: 8, hpol: 1'b1, vpol: 1'b0};
        rst_v = 4'b1111;
        repeat (2) cyc();
        test_reset();
        test_line_and_data();
        test_mid_reset();
        test_scaling();
        test_divider();
        test_frame();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
